dp_ram: RTL and testbench
=========================

Name: dp_ram

Overview:
- Dual-port 4x8 RAM with two independent read/write ports, A and B.
- Both ports run on a single shared clock.
- Used as a small shared scratch store between two agents in the same clock domain.
- Synchronous writes, registered synchronous reads, asynchronous active-high clear.

Parameters:
- DATA_WIDTH, 8, bits per word.
- ADDR_WIDTH, 2, address bits; depth = 2**ADDR_WIDTH (4 words).

Ports:
- clk  input  1  single clock for both ports; rising-edge active.
- reset  input  1  asynchronous, active-high; clears memory and outputs.
- we_A  input  1  port A write enable.
- address_A  input  ADDR_WIDTH  port A word address.
- data_in_A  input  DATA_WIDTH  port A write data.
- data_out_A  output  DATA_WIDTH  port A registered read data.
- we_B  input  1  port B write enable.
- address_B  input  ADDR_WIDTH  port B word address.
- data_in_B  input  DATA_WIDTH  port B write data.
- data_out_B  output  DATA_WIDTH  port B registered read data.

Behaviour:
- Reset:
  - Asynchronous, active-high; takes effect immediately, independent of clk.
  - Clears all memory words, data_out_A and data_out_B to 0.
  - Held for as long as reset=1.
  - A reset arriving mid-operation discards any pending write in that cycle.
- Writes, per port, every rising clk edge with reset=0:
  - we_X=1 stores data_in_X into mem[address_X].
  - Written data is visible to either port's read starting the next edge.
- Reads, per port, every rising edge with reset=0:
  - data_out_X <= mem[address_X], regardless of we_X.
  - Latency is 1 cycle: address presented before edge N appears on data_out after edge N.
- Read-during-write on the same port, same address: read-first; data_out returns the old contents.
- Cross-port read of an address the other port writes in the same cycle: returns the old contents.
- Both ports writing the same address in the same cycle: port A wins; port B's data is dropped.
- Both ports writing different addresses: both writes commit.
- No handshake; every cycle is a valid operation on each port.
- Addresses are exactly ADDR_WIDTH bits, so there are no out-of-range cases and no wrap-around concerns.

Optional Feature:
- Macro: DP_RAM_COLLISION_DETECT_EN.
- When defined:
  - Adds output collision (1 bit).
  - collision is registered and cleared to 0 by reset.
  - It is 1 for exactly the cycle after an edge where we_A=1, we_B=1 and address_A==address_B; otherwise 0.
- When undefined: no collision port and no extra logic.
- Core RAM behaviour, including port A priority, is identical either way.

Decomposition:
- Package dp_ram_pkg:
  - DATA_WIDTH / ADDR_WIDTH default constants.
  - DEPTH constant.
  - word_t and addr_t typedefs.
- Sub-module dp_ram_port: one port's read register and write-request qualification.
- Top instantiates dp_ram_port twice and owns the memory array plus the A-priority write arbitration.

Test Plan:
- Reset: assert reset=1 with arbitrary inputs, then release -> data_out_A=data_out_B=0x00; every address reads 0x00.
- Basic write/read: write A addr0=0x55, then B addr1=0x66; read A addr0 and B addr1 -> 0x55 and 0x66, each one cycle after the address is presented.
- Cross-port visibility: A writes addr2=0xC3; B reads addr2 the same edge -> old value 0x00; next read -> 0xC3.
- Write collision: A and B both write addr3 (A=0x11, B=0x22) -> addr3 reads 0x11. With DP_RAM_COLLISION_DETECT_EN, collision=1 for one cycle.
- Read-first same port: addr0 holds 0x55; A writes 0x77 to addr0 -> data_out_A shows 0x55 that cycle and 0x77 the next.
- Async reset mid-operation: assert reset between edges while writes are active -> outputs drop to 0 without a clock edge; all words read 0 after release.

Source files
------------

// File: rtl/dp_ram_pkg.sv
// Shared constants and types for the dual-port scratch RAM.
package dp_ram_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 2;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
endpackage

// File: rtl/dp_ram_port.sv
// One RAM port: registered read data plus the qualified write request it hands to the array.
module dp_ram_port #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] rd_word,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data
);
  // A write is never requested while reset is held, so nothing lands on release.
  assign wr_en   = we & ~reset;
  assign wr_addr = address;
  assign wr_data = data_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) data_out <= '0;
    else       data_out <= rd_word;
  end
endmodule

// File: rtl/dp_ram.sv
// Dual-port RAM, single clock, read-first, port A wins write collisions.
// Optional collision flag output enabled by DP_RAM_COLLISION_DETECT_EN.
module dp_ram
  import dp_ram_pkg::*;
#(
  parameter int DATA_WIDTH = dp_ram_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = dp_ram_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we_A,
  input  logic [ADDR_WIDTH-1:0] address_A,
  input  logic [DATA_WIDTH-1:0] data_in_A,
  output logic [DATA_WIDTH-1:0] data_out_A,
  input  logic                  we_B,
  input  logic [ADDR_WIDTH-1:0] address_B,
  input  logic [DATA_WIDTH-1:0] data_in_B,
  output logic [DATA_WIDTH-1:0] data_out_B
`ifdef DP_RAM_COLLISION_DETECT_EN
  ,
  output logic                  collision
`endif
);
  localparam int MEM_DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  wr_en_a, wr_en_b;
  logic [ADDR_WIDTH-1:0] wr_addr_a, wr_addr_b;
  logic [DATA_WIDTH-1:0] wr_data_a, wr_data_b;
  logic                  same_addr_wr;

  dp_ram_port #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_port_a (
    .clk(clk), .reset(reset), .we(we_A), .address(address_A), .data_in(data_in_A),
    .rd_word(mem[address_A]), .data_out(data_out_A),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a)
  );

  dp_ram_port #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_port_b (
    .clk(clk), .reset(reset), .we(we_B), .address(address_B), .data_in(data_in_B),
    .rd_word(mem[address_B]), .data_out(data_out_B),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b)
  );

  assign same_addr_wr = wr_en_a & wr_en_b & (wr_addr_a == wr_addr_b);

  // Port B is suppressed outright on a same-address collision rather than relying on NBA order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en_a)                 mem[wr_addr_a] <= wr_data_a;
      if (wr_en_b && !same_addr_wr) mem[wr_addr_b] <= wr_data_b;
    end
  end

`ifdef DP_RAM_COLLISION_DETECT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) collision <= 1'b0;
    else       collision <= same_addr_wr;
  end
`endif
endmodule

// File: tb/tb_dp_ram.sv
// Self-checking bench for dp_ram: directed scenarios plus randomized traffic against an array model.
module tb_dp_ram;
  import dp_ram_pkg::*;

  logic  clk = 1'b0;
  logic  reset;
  logic  we_A, we_B;
  addr_t address_A, address_B;
  word_t data_in_A, data_in_B, data_out_A, data_out_B;
`ifdef DP_RAM_COLLISION_DETECT_EN
  logic  collision;
  logic  m_coll;
`endif

  int errors = 0;
  int checks = 0;

  word_t m_mem [DEPTH];
  word_t m_out_a, m_out_b;

  dp_ram dut (
    .clk(clk), .reset(reset),
    .we_A(we_A), .address_A(address_A), .data_in_A(data_in_A), .data_out_A(data_out_A),
    .we_B(we_B), .address_B(address_B), .data_in_B(data_in_B), .data_out_B(data_out_B)
`ifdef DP_RAM_COLLISION_DETECT_EN
    , .collision(collision)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_out_a = '0;
    m_out_b = '0;
`ifdef DP_RAM_COLLISION_DETECT_EN
    m_coll = 1'b0;
`endif
  endtask

  // Advance one clock: the model samples the same inputs the DUT sees, then outputs are observed at negedge.
  task automatic step();
    word_t ra, rb;
    @(posedge clk);
    if (!reset) begin
      ra = m_mem[address_A];
      rb = m_mem[address_B];
`ifdef DP_RAM_COLLISION_DETECT_EN
      m_coll = we_A && we_B && (address_A == address_B);
`endif
      if (we_B) m_mem[address_B] = data_in_B;
      if (we_A) m_mem[address_A] = data_in_A;  // A applied last so it owns a shared address
      m_out_a = ra;
      m_out_b = rb;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic wa, input addr_t aa, input word_t da,
                       input logic wb, input addr_t ab, input word_t db);
    we_A = wa; address_A = aa; data_in_A = da;
    we_B = wb; address_B = ab; data_in_B = db;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, addr_t'($urandom), word_t'($urandom), 1'b1, addr_t'($urandom), word_t'($urandom));
    repeat (2) @(negedge clk);
    model_clear();
    checks++;
    if (data_out_A !== 8'h00 || data_out_B !== 8'h00) begin
      errors++;
      $display("FAIL reset_out: A=%h B=%h want 00 00", data_out_A, data_out_B);
    end
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      address_A = addr_t'(i);
      address_B = addr_t'(DEPTH - 1 - i);
      step();
      checks++;
      if (data_out_A !== 8'h00 || data_out_B !== 8'h00) begin
        errors++;
        $display("FAIL reset_mem[%0d]: A=%h B=%h want 00 00", i, data_out_A, data_out_B);
      end
    end
  endtask

  task automatic test_basic();
    drive(1'b1, 2'd0, 8'h55, 1'b0, 2'd3, 8'hFF);
    step();
    drive(1'b0, 2'd1, 8'h00, 1'b1, 2'd1, 8'h66);
    step();
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd1, 8'h00);
    step();
    checks++;
    if (data_out_A !== 8'h55 || data_out_B !== 8'h66) begin
      errors++;
      $display("FAIL basic_rw: A=%h B=%h want 55 66", data_out_A, data_out_B);
    end
  endtask

  task automatic test_cross_port();
    drive(1'b1, 2'd2, 8'hC3, 1'b0, 2'd2, 8'h00);
    step();
    checks++;
    if (data_out_B !== 8'h00) begin
      errors++;
      $display("FAIL cross_old: B=%h want 00", data_out_B);
    end
    drive(1'b0, 2'd2, 8'h00, 1'b0, 2'd2, 8'h00);
    step();
    checks++;
    if (data_out_B !== 8'hC3 || data_out_A !== 8'hC3) begin
      errors++;
      $display("FAIL cross_new: A=%h B=%h want c3 c3", data_out_A, data_out_B);
    end
  endtask

  task automatic test_collision();
    drive(1'b1, 2'd3, 8'h11, 1'b1, 2'd3, 8'h22);
    step();
`ifdef DP_RAM_COLLISION_DETECT_EN
    checks++;
    if (collision !== 1'b1) begin
      errors++;
      $display("FAIL collision_flag: got %b want 1", collision);
    end
`endif
    drive(1'b0, 2'd3, 8'h00, 1'b0, 2'd3, 8'h00);
    step();
    checks++;
    if (data_out_A !== 8'h11 || data_out_B !== 8'h11) begin
      errors++;
      $display("FAIL collision_data: A=%h B=%h want 11 11", data_out_A, data_out_B);
    end
`ifdef DP_RAM_COLLISION_DETECT_EN
    checks++;
    if (collision !== 1'b0) begin
      errors++;
      $display("FAIL collision_clear: got %b want 0", collision);
    end
`endif
    // Different addresses in the same cycle: both must commit.
    drive(1'b1, 2'd1, 8'hA1, 1'b1, 2'd2, 8'hB2);
    step();
    drive(1'b0, 2'd2, 8'h00, 1'b0, 2'd1, 8'h00);
    step();
    checks++;
    if (data_out_A !== 8'hB2 || data_out_B !== 8'hA1) begin
      errors++;
      $display("FAIL dual_write: A=%h B=%h want b2 a1", data_out_A, data_out_B);
    end
  endtask

  task automatic test_read_first();
    drive(1'b1, 2'd0, 8'h77, 1'b0, 2'd3, 8'h00);
    step();
    checks++;
    if (data_out_A !== 8'h55) begin
      errors++;
      $display("FAIL read_first_old: A=%h want 55", data_out_A);
    end
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd3, 8'h00);
    step();
    checks++;
    if (data_out_A !== 8'h77) begin
      errors++;
      $display("FAIL read_first_new: A=%h want 77", data_out_A);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 2'd1, 8'hEE, 1'b1, 2'd2, 8'hDD);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (data_out_A !== 8'h00 || data_out_B !== 8'h00) begin
      errors++;
      $display("FAIL async_reset_out: A=%h B=%h want 00 00", data_out_A, data_out_B);
    end
    model_clear();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    for (int i = 0; i < DEPTH; i++) begin
      address_A = addr_t'(i);
      address_B = addr_t'(i);
      step();
      checks++;
      if (data_out_A !== 8'h00 || data_out_B !== 8'h00) begin
        errors++;
        $display("FAIL async_reset_mem[%0d]: A=%h B=%h want 00 00", i, data_out_A, data_out_B);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      drive(1'($urandom), addr_t'($urandom), word_t'($urandom),
            1'($urandom), addr_t'($urandom), word_t'($urandom));
      step();
      checks++;
      if (data_out_A !== m_out_a || data_out_B !== m_out_b) begin
        errors++;
        $display("FAIL random[%0d]: A=%h B=%h want %h %h", n, data_out_A, data_out_B, m_out_a, m_out_b);
      end
`ifdef DP_RAM_COLLISION_DETECT_EN
      checks++;
      if (collision !== m_coll) begin
        errors++;
        $display("FAIL random_coll[%0d]: got %b want %b", n, collision, m_coll);
      end
`endif
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_cross_port();
    test_collision();
    test_read_first();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
